async_receiver: RTL and testbench
=================================

# async_receiver

RS-232 receive side of the serial link: recovers 8-bit characters from the asynchronous RxD line, 8N1 framing (8E1 when parity is compiled in), LSB first. It uses a 16x-oversampling phase-accumulator baud generator, a 2-flop synchronizer and 3-sample majority voting. Each character is delivered as a registered byte plus a one-cycle strobe, for the same host logic that drives the transmitter.

## Interface
- ClkFrequency, 50000000: clock frequency in Hz.
- Baud, 115200: line rate in bit/s.
- BaudGeneratorAccWidth, 16: accumulator fraction width W. The accumulator is W+1 bits.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- RxD  input  1  serial line, asynchronous to clk, idle high.
- RxD_data  output  8  last good character; reset 8'h00.
- RxD_data_ready  output  1  one-cycle strobe, RxD_data updated this cycle; reset 0.
- RxD_frame_err  output  1  one-cycle strobe, stop bit sampled low; reset 0.
- RxD_parity_err  output  1  one-cycle strobe, parity mismatch; reset 0, constant 0 without parity.
- RxD_busy  output  1  high while not in IDLE; reset 0.

## Operation
- Synchronizer: two flops, both reset to 1. The output is rxd_s.
- Oversample tick: acc <= acc[W-1:0] + Inc, free-running, reset 0. The tick is acc[W].
- Inc = ((Baud<<(W-3)) + (ClkFrequency>>8)) / (ClkFrequency>>7), computed in 32-bit integer arithmetic. At the defaults Inc = 2416, giving 1.8433 MHz, +0.003% error.
- Each state keeps a 4-bit tick counter, cnt, which wraps 15->0.
- Samples are taken at cnt 7, 8 and 9. The bit value is the majority of the three and is decided on the cnt==9 tick. The state advances on the cnt==15 tick.
- IDLE: on a tick with rxd_s==0, cnt<=1 and go to START.
- START: a majority of 1 at cnt 9 is a false start. Return to IDLE with no strobe.
- DATA: 8 bits, LSB first, shifted into an internal shift register. A 3-bit bit index runs 0..7. After bit 7, go to PARITY if present, otherwise STOP.
- PARITY: capture the bit; the running XOR of data+parity must be 0 (even parity).
- STOP: decide at cnt 9.
  - Majority 1: RxD_data <= shift register, pulse RxD_data_ready (and RxD_parity_err if mismatched), then go to IDLE immediately at cnt 9. Going at cnt 9 allows resync to a start bit in the second half of the stop bit.
  - Majority 0: pulse RxD_frame_err, leave RxD_data unchanged, go to BREAK.
- BREAK: wait for a tick with rxd_s==1, then go to IDLE. A held-low line produces only one frame_err.
- States (one-hot or binary): IDLE, START, DATA, PARITY, STOP, BREAK.

## Timing
- All strobes are registered. They rise in the clk cycle after the deciding tick and last exactly one clk.
- Latency from the RxD falling edge to RxD_data_ready at the defaults is about 9.56 bit times (8N1). Over 434 clks per bit this is about 4150 clks, ±1 tick plus 3 clks of synchronizer and register delay.
- Strobes never assert simultaneously, except data_ready with parity_err.
- Back-to-back characters with one stop bit must be received without loss.
- rst_n low mid-frame: all state, counters and outputs return to reset values in the next cycle. The partial character is discarded. After release, reception restarts at the next falling edge.
- RxD_busy rises the cycle after IDLE is left and falls the cycle after IDLE is entered.

## Configuration
- RXD_PARITY_EN defined: the PARITY state is present and one even-parity bit is expected between bit 7 and stop. RxD_parity_err is live.
- RXD_PARITY_EN undefined: 8N1 framing, PARITY state absent, RxD_parity_err tied 0.

## Test plan
- Reset: rst_n low 4 cycles with RxD=1 -> RxD_data=8'h00, all strobes 0, RxD_busy=0.
- Single frame 8'hA5 at 115200 baud -> exactly one RxD_data_ready, RxD_data=8'hA5, ~4150 clks after the start edge.
- Back-to-back 8'h00, 8'hFF, 8'h55 with one stop bit each -> three strobes, values in order.
- Glitch: RxD low for 3 bit-period/16 then high -> no strobe, RxD_busy returns to 0, next frame 8'h3C received correctly.
- Framing: 8'h81 sent with stop bit 0, RxD held low 20 bit times, then idle -> one RxD_frame_err, no data_ready, RxD_data unchanged, next frame 8'h7E received.
- Baud skew ±3% plus mid-frame reset: 8'hC3 at 111744 and 118656 baud -> both received. Assert rst_n low in bit 4 -> no strobe, next frame 8'h12 received (RXD_PARITY_EN: a bad parity bit on 8'h12 -> data_ready and parity_err in the same cycle).

Source files
------------

// File: rtl/async_receiver.sv
// async_receiver: 16x-oversampled RS-232 receiver, 8N1 by default, 8E1 when RXD_PARITY_EN is defined
`timescale 1ns/1ps
module async_receiver #(
    parameter int ClkFrequency          = 50000000,
    parameter int Baud                  = 115200,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_parity_err,
    output logic       RxD_busy
);
    localparam int W = BaudGeneratorAccWidth;
    localparam int INC_I = ((Baud << (W - 3)) + (ClkFrequency >> 8)) / (ClkFrequency >> 7);
    localparam logic [W:0] INC = INC_I[W:0];

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef RXD_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [1:0] sync;
    logic [W:0] acc;
    logic       tick, rxd_s, bit_v;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shift, shift_n, data_n;
    logic [1:0] smp, smp_n;
    logic       ready_n, ferr_n;
`ifdef RXD_PARITY_EN
    logic       par, par_n, perr, perr_n, pstb_n;
`endif

    assign rxd_s = sync[1];
    assign tick  = acc[W];
    assign bit_v = (smp[1] & smp[0]) | (smp[1] & rxd_s) | (smp[0] & rxd_s);

    // line synchronizer and free-running 16x baud phase accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b11;
            acc  <= '0;
        end else begin
            sync <= {sync[0], RxD};
            acc  <= {1'b0, acc[W-1:0]} + INC;
        end
    end

    // frame sequencing: samples at ticks 7/8/9, decides at 9, advances at 15
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        smp_n   = smp;
        data_n  = RxD_data;
        ready_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef RXD_PARITY_EN
        par_n   = par;
        perr_n  = perr;
        pstb_n  = 1'b0;
`endif
        if (tick) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) smp_n[1] = rxd_s;
            if (cnt == 4'd8) smp_n[0] = rxd_s;
            case (state)
                IDLE: begin
                    cnt_n = 4'd1;
                    if (!rxd_s) begin
                        state_n = START;
                        idx_n   = 3'd0;
`ifdef RXD_PARITY_EN
                        par_n   = 1'b0;
                        perr_n  = 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt == 4'd9 && bit_v) state_n = IDLE;
                    else if (cnt == 4'd15) state_n = DATA;
                end
                DATA: begin
                    if (cnt == 4'd9) begin
                        shift_n = {bit_v, shift[7:1]};
`ifdef RXD_PARITY_EN
                        par_n   = par ^ bit_v;
`endif
                    end
                    if (cnt == 4'd15) begin
                        idx_n = idx + 3'd1;
`ifdef RXD_PARITY_EN
                        if (idx == 3'd7) state_n = PARITY;
`else
                        if (idx == 3'd7) state_n = STOP;
`endif
                    end
                end
`ifdef RXD_PARITY_EN
                PARITY: begin
                    if (cnt == 4'd9) perr_n = par ^ bit_v;
                    if (cnt == 4'd15) state_n = STOP;
                end
`endif
                STOP: begin
                    if (cnt == 4'd9) begin
                        if (bit_v) begin
                            data_n  = shift;
                            ready_n = 1'b1;
`ifdef RXD_PARITY_EN
                            pstb_n  = perr;
`endif
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end
                    end
                end
                BREAK: if (rxd_s) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // state, datapath and registered strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            idx            <= 3'd0;
            shift          <= 8'h00;
            smp            <= 2'b00;
            RxD_data       <= 8'h00;
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
            RxD_busy       <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            shift          <= shift_n;
            smp            <= smp_n;
            RxD_data       <= data_n;
            RxD_data_ready <= ready_n;
            RxD_frame_err  <= ferr_n;
            RxD_busy       <= state_n != IDLE;
        end
    end

`ifdef RXD_PARITY_EN
    // running even-parity check and its strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par            <= 1'b0;
            perr           <= 1'b0;
            RxD_parity_err <= 1'b0;
        end else begin
            par            <= par_n;
            perr           <= perr_n;
            RxD_parity_err <= pstb_n;
        end
    end
`else
    assign RxD_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_async_receiver.sv
// tb_async_receiver: randomized and directed frames checked against a frame-level model
`timescale 1ns/1ps
module tb_async_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready, RxD_frame_err, RxD_parity_err, RxD_busy;

    int vectors = 0, miscompares = 0;
    int n_ready = 0, n_ferr = 0, n_perr = 0, n_pair = 0, n_clash = 0;
    int exp_ready = 0, exp_ferr = 0, exp_perr = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    time t_ready = 0;

    localparam int BT = 1000000000 / 115200;

    async_receiver dut (
        .clk(clk), .rst_n(rst_n), .RxD(RxD),
        .RxD_data(RxD_data), .RxD_data_ready(RxD_data_ready),
        .RxD_frame_err(RxD_frame_err), .RxD_parity_err(RxD_parity_err),
        .RxD_busy(RxD_busy)
    );

    always #10 clk = ~clk;

    // strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (RxD_data_ready) begin
            rx_q.push_back(RxD_data);
            t_ready = $time;
        end
        n_ready += int'(RxD_data_ready);
        n_ferr  += int'(RxD_frame_err);
        n_perr  += int'(RxD_parity_err);
        if (RxD_data_ready && RxD_parity_err) n_pair++;
        if (RxD_frame_err && (RxD_data_ready || RxD_parity_err)) n_clash++;
        if (RxD_parity_err && !RxD_data_ready) n_clash++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int baud, input logic stop_v, input logic par_flip);
        int bt;
        bt = 1000000000 / baud;
        RxD = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            #(bt);
        end
`ifdef RXD_PARITY_EN
        RxD = (^d) ^ par_flip;
        #(bt);
`else
        if (par_flip) #0;
`endif
        RxD = stop_v;
        #(bt);
    endtask

    // frame-level model: a good stop bit delivers the byte, a bad one a framing error
    task automatic model(input logic [7:0] d, input logic stop_v, input logic par_flip);
        if (stop_v) begin
            exp_q.push_back(d);
            exp_ready++;
`ifdef RXD_PARITY_EN
            if (par_flip) exp_perr++;
`else
            if (par_flip) exp_perr += 0;
`endif
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic frame(input logic [7:0] d, input int baud, input logic stop_v, input logic par_flip);
        model(d, stop_v, par_flip);
        send(d, baud, stop_v, par_flip);
    endtask

    task automatic drain(input string tag);
        sync_pt();
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) check(tag, rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        exp_q.delete();
        check({tag, "_ready"}, n_ready, exp_ready);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_perr"}, n_perr, exp_perr);
    endtask

    initial begin
        logic [7:0] d;
        int   baud, lat;
        logic pf;
        time  t0;
        // reset with the line idle
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", RxD_data, 8'h00);
        check("rst_ready", RxD_data_ready, 1'b0);
        check("rst_ferr", RxD_frame_err, 1'b0);
        check("rst_perr", RxD_parity_err, 1'b0);
        check("rst_busy", RxD_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #(BT);
        // single frame and latency
        t0 = $time;
        frame(8'hA5, 115200, 1'b1, 1'b0);
        drain("a5");
        lat = int'((t_ready - t0) / 20);
        check("a5_latency_ok", (lat >= 4140 && lat <= 4195), 1'b1);
        check("a5_data", RxD_data, 8'hA5);
        // back-to-back
        frame(8'h00, 115200, 1'b1, 1'b0);
        frame(8'hFF, 115200, 1'b1, 1'b0);
        frame(8'h55, 115200, 1'b1, 1'b0);
        drain("b2b");
        // glitch rejected, then a good frame
        RxD = 1'b0;
        #(3 * BT / 16);
        RxD = 1'b1;
        #(BT);
        sync_pt();
        check("glitch_busy", RxD_busy, 1'b0);
        check("glitch_ready", n_ready, exp_ready);
        frame(8'h3C, 115200, 1'b1, 1'b0);
        drain("after_glitch");
        // framing error then held break
        frame(8'h81, 115200, 1'b0, 1'b0);
        #(20 * BT);
        RxD = 1'b1;
        #(BT);
        drain("framing");
        check("framing_data_kept", RxD_data, 8'h3C);
        check("framing_busy", RxD_busy, 1'b0);
        frame(8'h7E, 115200, 1'b1, 1'b0);
        drain("after_break");
        // baud skew
        frame(8'hC3, 111744, 1'b1, 1'b0);
        #(BT / 2);
        frame(8'hC3, 118656, 1'b1, 1'b0);
        drain("skew");
        // randomized frames with random skew and gaps
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            baud = 115200 * int'($urandom_range(98, 102)) / 100;
            pf = 1'($urandom);
            frame(d, baud, 1'b1, pf);
            #(BT * int'($urandom_range(0, 2)) / 2);
        end
        drain("random");
        check("random_data", RxD_data, 32'(d));
        // reset in bit 4, held until the line has finished the frame
        fork
            send(8'hC3, 115200, 1'b1, 1'b0);
            begin
                #(BT * 5 + BT / 2);
                sync_pt();
                check("mid_busy", RxD_busy, 1'b1);
                @(negedge clk);
                rst_n = 1'b0;
                sync_pt();
                check("mid_rst_busy", RxD_busy, 1'b0);
                check("mid_rst_data", RxD_data, 8'h00);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        #(BT);
        drain("mid_rst");
        frame(8'h12, 115200, 1'b1, 1'b1);
        drain("after_rst");
        check("pair_count", n_pair, exp_perr);
        check("strobe_clash", n_clash, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
